// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction prefetch buffer between instruction memory and
//                the IF/ID register. Fetches sequential 16-bit instructions
//                over a req/ack handshake and queues up to DEPTH entries of
//                {instr, pc+2}. A redirect flushes the queue and restarts
//                fetching at the new address.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [15:0]              redirect_pc,
    input  logic                     halt,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [15:0]              mem_rdata,
    output logic                     out_valid,
    output logic [15:0]              out_instr,
    output logic [15:0]              out_pc_next,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [15:0]      c_pc_step = 16'd2;

    // IDLE: free to issue; WAIT: request outstanding, data will be kept;
    // DISCARD: request outstanding but a redirect made its data stale.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [15:0]        fetch_pc_q, fetch_pc_d;
    logic               mem_req_q,  mem_req_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;

    logic [15:0]        instr_mem_q   [DEPTH];
    logic [15:0]        instr_mem_d   [DEPTH];
    logic [15:0]        pc_next_mem_q [DEPTH];
    logic [15:0]        pc_next_mem_d [DEPTH];

    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic [15:0]        w_pc_plus2;

    // fetch_pc always equals mem_addr while a kept request is outstanding,
    // so the stored link address is simply fetch_pc+2 (16-bit wrap).
    assign w_pc_plus2  = fetch_pc_q + c_pc_step;
    assign w_not_empty = (count_q != '0);

    // A redirect cancels any pop in the same cycle; the queue is flushed.
    assign w_pop = w_not_empty && out_ready && !redirect_valid;

    // Fetch sequencer: issue, wait for ack, decide whether to keep the data.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        w_push     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // In IDLE nothing is outstanding, so count alone is the
                // occupancy including the request about to be issued.
                // A redirect this cycle changes fetch_pc, so wait for it.
                if (!redirect_valid && !halt && (count_q < c_depth)) begin
                    state_d    = S_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    if (!redirect_valid) begin
                        w_push     = 1'b1;
                        fetch_pc_d = w_pc_plus2;
                    end
                end else if (redirect_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // Keep the old request on the bus until memory finishes it.
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // The newest redirect always wins the next fetch address.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // Queue pointers and occupancy; redirect flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            unique case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    // Entry storage: write the returned word and its link address on push.
    always_comb begin
        instr_mem_d   = instr_mem_q;
        pc_next_mem_d = pc_next_mem_q;
        if (w_push) begin
            instr_mem_d[wr_ptr_q]   = mem_rdata;
            pc_next_mem_d[wr_ptr_q] = w_pc_plus2;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instr_mem_q   <= '{default: '0};
            pc_next_mem_q <= '{default: '0};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_mem_q   <= instr_mem_d;
            pc_next_mem_q <= pc_next_mem_d;
        end
    end

    // Head entry is shown straight from storage and forced to 0 when empty.
    always_comb begin
        out_valid   = w_not_empty;
        out_instr   = '0;
        out_pc_next = '0;
        if (w_not_empty) begin
            out_instr   = instr_mem_q[rd_ptr_q];
            out_pc_next = pc_next_mem_q[rd_ptr_q];
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. A transaction-level
//                reference (expected instruction queue, expected next fetch
//                address, request-in-flight flags) is advanced once per cycle
//                from the same inputs the DUT sees; directed phases cover the
//                handshake corner cases, then a randomized phase runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          CNT_W    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [15:0]       redirect_pc = '0;
    logic              halt = 1'b0;
    logic              mem_req;
    logic [15:0]       mem_addr;
    logic              mem_ack = 1'b0;
    logic [15:0]       mem_rdata = '0;
    logic              out_valid;
    logic [15:0]       out_instr;
    logic [15:0]       out_pc_next;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc_next    (out_pc_next),
        .out_ready      (out_ready),
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];          // expected queue entries {instr, pc_next}
    logic [15:0] m_fetch;        // address the next new request must use
    bit          m_inflight;     // a request is outstanding
    bit          m_discard;      // outstanding request's data is stale
    bit          exp_req;        // expected mem_req in the coming cycle
    logic [15:0] exp_addr;       // expected mem_addr while exp_req

    // memory responder
    int          lat_cfg = 1;    // wait cycles before ack, -1 = random 0..3
    int          lat_left = 0;
    bit          lat_armed = 0;
    bit          stray_ack = 0;
    bit          rel_rst = 0;

    // observation logs
    bit          prev_req = 0;
    bit          req_rose = 0;
    logic [15:0] req_log[$];
    logic [15:0] pop_log[$];

    function automatic logic [15:0] at(input logic [15:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 16'hDEAD;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fetch    = RESET_PC;
        m_inflight = 0;
        m_discard  = 0;
        exp_req    = 0;
        exp_addr   = '0;
        lat_armed  = 0;
        prev_req   = 0;
    endtask

    // One clock cycle: check outputs against the model, drive inputs,
    // then advance the model to what the next rising edge must produce.
    task automatic cycle(input bit rdy, input bit hlt, input bit rv, input logic [15:0] rpc);
        int          sz;
        bit          a;
        bit          pop;
        logic [15:0] link;
        @(negedge clk);
        if (rel_rst) begin
            rst     = 1'b1;
            rel_rst = 0;
        end
        sz = mq.size();
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("out_instr", 32'(out_instr), (sz != 0) ? 32'(mq[0][31:16]) : 32'h0);
        check("out_pc_next", 32'(out_pc_next), (sz != 0) ? 32'(mq[0][15:0]) : 32'h0);
        check("count", 32'(count), 32'(sz));

        req_rose = mem_req && !prev_req;
        if (req_rose) req_log.push_back(mem_addr);
        prev_req = mem_req;

        out_ready      = rdy;
        halt           = hlt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_rdata      = 16'($urandom);
        a = 0;
        if (mem_req) begin
            if (!lat_armed) begin
                lat_armed = 1;
                lat_left  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            end
            if (lat_left == 0) begin
                a = 1;
                lat_armed = 0;
            end else begin
                lat_left--;
            end
        end
        mem_ack   = a | stray_ack;
        a         = mem_ack;
        stray_ack = 0;

        pop = (sz != 0) && rdy && !rv;
        if (pop) pop_log.push_back(out_pc_next);
        if (rv) mq.delete();
        else if (pop) void'(mq.pop_front());

        if (m_inflight) begin
            if (a) begin
                if (!m_discard && !rv) begin
                    link = exp_addr + 16'd2;
                    mq.push_back({mem_rdata, link});
                    m_fetch = link;
                end
                m_inflight = 0;
                m_discard  = 0;
                exp_req    = 0;
            end else begin
                if (rv) m_discard = 1;
                exp_req = 1;
            end
        end else if (!hlt && (sz < DEPTH) && !rv) begin
            m_inflight = 1;
            exp_req    = 1;
            exp_addr   = m_fetch;
        end else begin
            exp_req = 0;
        end
        if (rv) m_fetch = rpc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   32'(mem_req),     32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr),    32'h0);
        check({tag, "_out_valid"}, 32'(out_valid),   32'h0);
        check({tag, "_out_instr"}, 32'(out_instr),   32'h0);
        check({tag, "_out_pcn"},   32'(out_pc_next), 32'h0);
        check({tag, "_count"},     32'(count),       32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        logic [15:0] rpc;

        // ---- reset state ----
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");

        // ---- sequential fetch, ack one cycle after request, drain ----
        rel_rst = 1;
        lat_cfg = 1;
        req_log.delete(); pop_log.delete();
        repeat (20) cycle(1, 0, 0, 16'h0);
        check("seq_addr0", 32'(at(req_log, 0)), 32'h0000);
        check("seq_addr1", 32'(at(req_log, 1)), 32'h0002);
        check("seq_addr2", 32'(at(req_log, 2)), 32'h0004);
        check("seq_pcn0",  32'(at(pop_log, 0)), 32'h0002);
        check("seq_pcn1",  32'(at(pop_log, 1)), 32'h0004);
        check("seq_pcn2",  32'(at(pop_log, 2)), 32'h0006);

        // ---- fill to DEPTH with out_ready low ----
        repeat (8) cycle(1, 1, 0, 16'h0);          // halt: drain to empty
        check("drain_count", 32'(count), 32'h0);
        req_log.delete();
        repeat (30) cycle(0, 0, 0, 16'h0);
        check("full_reqs",  32'(req_log.size()), 32'(DEPTH));
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_noreq", 32'(mem_req), 32'h0);
        cycle(1, 0, 0, 16'h0);                      // single pop
        repeat (4) cycle(0, 0, 0, 16'h0);
        check("refill_reqs", 32'(req_log.size()), 32'(DEPTH + 1));

        // ---- redirect with 3 queued and a request in flight ----
        lat_cfg = 3;
        cycle(1, 0, 0, 16'h0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, 0, 0, 16'h0);
            found = req_rose;
        end
        check("redir_found", 32'(found), 32'h1);
        check("redir_pre_count", 32'(count), 32'd3);
        req_log.delete(); pop_log.delete();
        cycle(0, 0, 1, 16'h0100);
        cycle(0, 0, 0, 16'h0);
        check("redir_count0", 32'(count), 32'h0);
        lat_cfg = 1;
        repeat (15) cycle(1, 0, 0, 16'h0);
        check("redir_addr", 32'(at(req_log, 0)), 32'h0100);
        check("redir_pcn",  32'(at(pop_log, 0)), 32'h0102);

        // ---- redirect in the same cycle as the ack, head valid and ready ----
        lat_cfg = 2;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, 0, 0, 16'h0);
            found = req_rose && (count != 0);
        end
        check("same_found", 32'(found), 32'h1);
        cycle(0, 0, 0, 16'h0);
        req_log.delete();
        cycle(1, 0, 1, 16'h0200);                  // ack arrives this cycle
        cycle(0, 0, 0, 16'h0);
        check("same_count0", 32'(count), 32'h0);
        repeat (10) cycle(0, 0, 0, 16'h0);
        check("same_addr", 32'(at(req_log, 0)), 32'h0200);

        // ---- halt while a request is outstanding ----
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1, 0, 0, 16'h0);
            found = req_rose;
        end
        check("halt_found", 32'(found), 32'h1);
        req_log.delete();
        repeat (15) cycle(1, 1, 0, 16'h0);
        check("halt_noreq",  32'(req_log.size()), 32'h0);
        check("halt_count0", 32'(count), 32'h0);
        cycle(1, 0, 0, 16'h0);                      // halt falls here
        cycle(1, 0, 0, 16'h0);
        check("halt_resume", 32'(mem_req), 32'h1);

        // ---- redirect to the top of the address space ----
        lat_cfg = 1;
        req_log.delete();
        cycle(0, 0, 1, 16'hFFFE);
        repeat (12) cycle(0, 0, 0, 16'h0);
        check("wrap_addr0", 32'(at(req_log, 0)), 32'hFFFE);
        check("wrap_addr1", 32'(at(req_log, 1)), 32'h0000);
        check("wrap_pcn",   32'(out_pc_next), 32'h0000);

        // ---- randomized traffic ----
        lat_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            rpc = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 3) == 0) rpc = 16'hFFF8 | (rpc & 16'h0006);
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 19) == 0), rpc);
        end

        // ---- asynchronous reset with a request in flight ----
        lat_cfg = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(0, 0, 0, 16'h0);
            found = req_rose;
        end
        check("arst_found", 32'(found), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        mem_ack = 1'b0;
        req_log.delete();
        stray_ack = 1;                              // ack right after release
        rel_rst   = 1;
        lat_cfg   = 1;
        repeat (10) cycle(1, 0, 0, 16'h0);
        check("arst_addr", 32'(at(req_log, 0)), 32'(RESET_PC));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer sitting between the instruction memory and the IF/ID pipeline register.
- Runs ahead of the pipeline by fetching sequential 16-bit instructions over a req/ack memory handshake that may take several cycles per access.
- Holds up to DEPTH fetched instructions, each with its PC+2, and hands them to IF/ID over a valid/ready interface.
- On a taken branch or jump it flushes its contents and restarts fetching at the redirect address.

Parameters:
- DEPTH, 4, number of instruction entries held; power of two, minimum 2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  branch/jump taken in ID; flush the queue and restart fetching.
- redirect_pc  input  16  new fetch address, sampled when redirect_valid=1.
- halt  input  1  stop issuing new memory requests while high (level).
- mem_req  output  1  memory read request.
- mem_addr  output  16  byte address of the requested instruction.
- mem_ack  input  1  memory returns mem_rdata this cycle; completes the request.
- mem_rdata  input  16  instruction word, valid while mem_ack=1.
- out_valid  output  1  head entry is valid.
- out_instr  output  16  instruction at head.
- out_pc_next  output  16  PC+2 of the head instruction, feeding the IF/ID PC input.
- out_ready  input  1  IF/ID accepts the head this cycle.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; queue empty; count=0.
  - out_valid=0, out_instr=0, out_pc_next=0.
  - mem_req=0, mem_addr=0; state=IDLE.
  - Reset asserted mid-request drops the request; an ack arriving in the first cycle after reset release is ignored because state is IDLE.
- Storage: circular buffer, read and write pointers wrap modulo DEPTH. Each entry holds {instr, pc+2}.
- Output:
  - out_valid = (count!=0).
  - out_instr and out_pc_next show the head entry combinationally from storage; both read 0 when the queue is empty.
  - Pop occurs when out_valid && out_ready && !redirect_valid.
- Fetch state machine:
  - IDLE: when halt=0 and (count + 0) < DEPTH, go to WAIT and drive mem_req=1, mem_addr=fetch_pc on the next cycle.
  - WAIT: mem_req and mem_addr are held stable until mem_ack. On mem_ack with no redirect:
    - push {mem_rdata, fetch_pc+2};
    - fetch_pc <= fetch_pc+2;
    - mem_req drops the following cycle. The state returns to IDLE, so at most one request is in flight and back-to-back requests are separated by one idle cycle.
    - The free-slot check counts the outstanding request, so a push can never overflow.
  - DISCARD: entered when redirect_valid=1 while in WAIT without mem_ack. mem_req stays high with the old address until mem_ack. That ack's data is dropped, then the state goes to IDLE with fetch_pc already set to the redirect address.
- Redirect (redirect_valid=1), applied at the clock edge:
  - queue emptied (count=0, pointers reset);
  - fetch_pc <= redirect_pc;
  - a simultaneous pop is cancelled.
- Simultaneous events:
  - Redirect and mem_ack in the same cycle: the ack data is discarded, state goes to IDLE, fetch_pc=redirect_pc.
  - Redirect in DISCARD: fetch_pc updated to the newest redirect_pc; remain in DISCARD.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
- Full: count==DEPTH means no new request; a request issues on the cycle after a pop frees a slot.
- Halt:
  - Blocks only new request issue.
  - An in-flight request completes and is pushed.
  - The queue keeps draining to IF/ID.
  - Redirect is still honoured.
- Arithmetic: fetch_pc+2 is 16-bit and wraps, so 16'hFFFE is followed by 16'h0000. The stored pc+2 for address 16'hFFFE is 16'h0000.
- Latency: an ack in cycle N gives out_valid=1 in cycle N+1.
- No input is combinationally fed through to any output except via storage.

Test Plan:
- Reset, then release with mem_ack returned one cycle after each mem_req, and out_ready=1:
  - mem_addr sequence is 0x0000, 0x0002, 0x0004.
  - out_instr matches mem_rdata and out_pc_next is 0x0002, 0x0004, 0x0006.
  - Each output appears one cycle after its ack.
- Hold out_ready=0 with DEPTH=4:
  - exactly 4 requests issue, then count=4 and mem_req stays 0;
  - one pop yields a new request on the next cycle.
- Pulse redirect_valid with redirect_pc=0x0100 while 3 entries are queued and a request is in flight:
  - count=0 next cycle;
  - the in-flight ack data is discarded;
  - the next mem_addr is 0x0100 and the first delivered out_pc_next is 0x0102.
- Assert redirect_valid in the same cycle as mem_ack, with out_valid=1 and out_ready=1:
  - no pop and no push occur;
  - fetch restarts at redirect_pc.
- Assert halt in WAIT:
  - the outstanding ack is still pushed;
  - no further mem_req occurs while halt=1, and the queue drains to 0;
  - fetching resumes the cycle after halt falls.
- Redirect to 0xFFFE:
  - fetched entry out_pc_next=0x0000;
  - the next mem_addr is 0x0000 (wrap-around).
- Pulse rst low while a request is in flight:
  - all outputs are 0 immediately (asynchronous reset);
  - after release, the first mem_addr is RESET_PC.
